// File: rtl/nibble_serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT bits per clock,
// LSB slice first, with valid/ready handshakes and borrow/overflow/zero flags.
module nibble_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     a_q, b_q, part_q;
  logic                 borrow_chain;
  logic [CNT_W-1:0]     cnt;
  logic [DIGIT:0]       slice_sum;
  logic                 slice_borrow;
  logic [WIDTH+DIGIT-1:0] part_shift;
  logic [WIDTH-1:0]     diff_next;
  logic                 last_slice;

  // Operands shift right one slice per cycle, so the active slice is always
  // in the low DIGIT bits; the partial result fills in from the top.
  always_comb begin
    slice_sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, ~b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, ~borrow_chain};
    slice_borrow = ~slice_sum[DIGIT];
    part_shift   = {slice_sum[DIGIT-1:0], part_q};
    diff_next    = part_shift[WIDTH+DIGIT-1:DIGIT];
    last_slice   = (cnt == LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every path of a combinational block must assign each output, so a
  // default is written first; otherwise a latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (valid_i)    state_next = CALC;
      CALC: if (last_slice) state_next = DONE;
      DONE: if (ready_i)    state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q          <= '0;
      b_q          <= '0;
      part_q       <= '0;
      borrow_chain <= 1'b0;
      cnt          <= '0;
      diff_o       <= '0;
      borrow_o     <= 1'b0;
      overflow_o   <= 1'b0;
      zero_o       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            a_q          <= a_i;
            b_q          <= b_i;
            borrow_chain <= borrow_i;
            part_q       <= '0;
            cnt          <= '0;
          end
        end
        CALC: begin
          a_q          <= a_q >> DIGIT;
          b_q          <= b_q >> DIGIT;
          part_q       <= diff_next;
          borrow_chain <= slice_borrow;
          cnt          <= cnt + 1'b1;
          if (last_slice) begin
            // On the last slice the low bits of a_q/b_q hold the operand MSBs.
            diff_o     <= diff_next;
            borrow_o   <= slice_borrow;
            overflow_o <= (a_q[DIGIT-1] != b_q[DIGIT-1]) &&
                          (diff_next[WIDTH-1] != a_q[DIGIT-1]);
            zero_o     <= (diff_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench for nibble_serial_subtractor: reset, arithmetic vectors,
// backpressure, handshake timing and reset mid-operation.
module tb_nibble_serial_subtractor;

  localparam int WIDTH   = 32;
  localparam int DIGIT   = 4;
  localparam int LATENCY = WIDTH / DIGIT;
  localparam int BOUND   = 50;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             borrow_i = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b0;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             overflow_o;
  logic             zero_o;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bo;
    logic             ov;
    logic             z;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  nibble_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .borrow_i   (borrow_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .diff_o     (diff_o),
    .borrow_o   (borrow_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    logic [WIDTH:0] full;
    exp_t e;
    full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    e.diff = full[WIDTH-1:0];
    e.bo   = full[WIDTH];
    e.ov   = (a[WIDTH-1] != b[WIDTH-1]) && (e.diff[WIDTH-1] != a[WIDTH-1]);
    e.z    = (e.diff == '0);
    return e;
  endfunction

  // Drives one operand set; returns at the negedge after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!ready_o && n < BOUND) begin
      @(negedge clk_i);
      n++;
    end
    n_vec++;
    if (!ready_o) begin
      n_miss++;
      $display("FAIL send_ready: ready_o=%0b required 1 within %0d cycles", ready_o, BOUND);
    end
    a_i = a; b_i = b; borrow_i = bin; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    a_i = $urandom; b_i = $urandom; borrow_i = 1'($urandom);
    sb.push_back(model(a, b, bin));
  endtask

  // Waits (bounded) for valid_o; lat = clock edges after the accepting edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!valid_o && lat < BOUND) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic handshake;
    ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if ({ready_o, valid_o, diff_o, borrow_o, overflow_o, zero_o} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 3'b000}) begin
      n_miss++;
      $display("FAIL reset_state: rdy=%0b vld=%0b diff=%h bo=%0b ov=%0b z=%0b required rdy=1 vld=0 rest 0",
               ready_o, valid_o, diff_o, borrow_o, overflow_o, zero_o);
    end
  endtask

  task automatic test_arith;
    logic [WIDTH-1:0] ta [10];
    logic [WIDTH-1:0] tb [10];
    logic             tc [10];
    int   lat;
    exp_t e;
    ta = '{32'd5, 32'd3, 32'h8000_0000, 32'd7, 32'd0, 32'h7FFF_FFFF, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h0};
    tb = '{32'd3, 32'd5, 32'd1,         32'd7, 32'd0, 32'hFFFF_FFFF, 32'h1234_5677, 32'h0, 32'hFFFF_FFFF, 32'h1};
    tc = '{1'b0,  1'b0,  1'b0,          1'b0,  1'b1,  1'b0,          1'b1,          1'b0,  1'b1,          1'b0};
    for (int i = 0; i < 14; i++) begin
      if (i < 10) send(ta[i], tb[i], tc[i]);
      else        send($urandom, $urandom, 1'($urandom));
      wait_result(lat);
      e = sb.pop_front();
      n_vec++;
      if (lat != LATENCY) begin
        n_miss++;
        $display("FAIL arith_latency[%0d]: got %0d edges required %0d", i, lat, LATENCY);
      end
      n_vec++;
      if ({diff_o, borrow_o, overflow_o, zero_o} !== {e.diff, e.bo, e.ov, e.z}) begin
        n_miss++;
        $display("FAIL arith_result[%0d]: diff=%h bo=%0b ov=%0b z=%0b required diff=%h bo=%0b ov=%0b z=%0b",
                 i, diff_o, borrow_o, overflow_o, zero_o, e.diff, e.bo, e.ov, e.z);
      end
      handshake();
      n_vec++;
      if ({valid_o, ready_o, diff_o, zero_o} !== {1'b0, 1'b1, e.diff, e.z}) begin
        n_miss++;
        $display("FAIL arith_after_hs[%0d]: vld=%0b rdy=%0b diff=%h z=%0b required vld=0 rdy=1 diff=%h z=%0b",
                 i, valid_o, ready_o, diff_o, zero_o, e.diff, e.z);
      end
    end
  endtask

  task automatic test_backpressure;
    int   lat;
    exp_t e;
    send(32'h0000_0100, 32'h0000_0001, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != LATENCY) begin
      n_miss++;
      $display("FAIL bp_latency: got %0d edges required %0d", lat, LATENCY);
    end
    for (int i = 0; i < 5; i++) begin
      a_i = $urandom; b_i = $urandom; valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      n_vec++;
      if ({valid_o, ready_o, diff_o, borrow_o, overflow_o, zero_o} !== {1'b1, 1'b0, e.diff, e.bo, e.ov, e.z}) begin
        n_miss++;
        $display("FAIL bp_hold[%0d]: vld=%0b rdy=%0b diff=%h bo=%0b ov=%0b z=%0b required vld=1 rdy=0 diff=%h bo=%0b ov=%0b z=%0b",
                 i, valid_o, ready_o, diff_o, borrow_o, overflow_o, zero_o, e.diff, e.bo, e.ov, e.z);
      end
    end
    valid_i = 1'b0;
    handshake();
    n_vec++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_miss++;
      $display("FAIL bp_release: rdy=%0b vld=%0b required rdy=1 vld=0", ready_o, valid_o);
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    exp_t e;
    send(32'h0000_0010, 32'h0000_0020, 1'b1);
    wait_result(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != LATENCY || {diff_o, borrow_o, overflow_o, zero_o} !== {e.diff, e.bo, e.ov, e.z}) begin
      n_miss++;
      $display("FAIL b2b_result: lat=%0d diff=%h bo=%0b ov=%0b z=%0b required lat=%0d diff=%h bo=%0b ov=%0b z=%0b",
               lat, diff_o, borrow_o, overflow_o, zero_o, LATENCY, e.diff, e.bo, e.ov, e.z);
    end
    // Operands offered during the result handshake must not be taken.
    a_i = 32'hDEAD_BEEF; b_i = 32'h1; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ready_i = 1'b0; valid_i = 1'b0;
    n_vec++;
    if ({ready_o, valid_o} !== 2'b10) begin
      n_miss++;
      $display("FAIL b2b_no_accept_in_hs: rdy=%0b vld=%0b required rdy=1 vld=0", ready_o, valid_o);
    end
  endtask

  task automatic test_reset_mid_calc;
    int   lat;
    exp_t e;
    send(32'h0000_0099, 32'h0000_0011, 1'b0);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    void'(sb.pop_back());
    n_vec++;
    if ({ready_o, valid_o, diff_o, borrow_o, overflow_o, zero_o} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 3'b000}) begin
      n_miss++;
      $display("FAIL mid_reset_state: rdy=%0b vld=%0b diff=%h bo=%0b ov=%0b z=%0b required rdy=1 vld=0 rest 0",
               ready_o, valid_o, diff_o, borrow_o, overflow_o, zero_o);
    end
    send(32'd10, 32'd4, 1'b0);
    wait_result(lat);
    e = sb.pop_front();
    n_vec++;
    if (lat != LATENCY || diff_o !== 32'd6 || {borrow_o, overflow_o, zero_o} !== {e.bo, e.ov, e.z}) begin
      n_miss++;
      $display("FAIL mid_reset_recover: lat=%0d diff=%h bo=%0b ov=%0b z=%0b required lat=%0d diff=00000006 bo=%0b ov=%0b z=%0b",
               lat, diff_o, borrow_o, overflow_o, zero_o, LATENCY, e.bo, e.ov, e.z);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
